// File: rtl/onchip_mem_pkg.sv
// Shared constants and types for the on-chip main-memory arbiter.
package onchip_mem_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    // Requester identity; also the encoding of the round-robin pointer.
    typedef enum logic {
        REQ_M0 = 1'b0,
        REQ_M1 = 1'b1
    } req_id_t;

endpackage

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
// Two-way arbiter: combinational one-hot grant, registered last-grant pointer.
module rr_arb2
    import onchip_mem_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    req_id_t    r_last;
    logic [1:0] w_gnt;

    // Pick the winner: fixed m0 priority, or the requester that did not win last.
    always_comb begin
        w_gnt = 2'b00;
        if (FIXED_PRIO != 0) begin
            if (i_req[0])      w_gnt = 2'b01;
            else if (i_req[1]) w_gnt = 2'b10;
        end else begin
            case (i_req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = (r_last == REQ_M1) ? 2'b01 : 2'b10;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    // Remember who won; reset to m1 so that m0 takes the first contended grant.
    always_ff @(posedge clk) begin
        if (reset)
            r_last <= REQ_M1;
        else if (|w_gnt)
            r_last <= w_gnt[1] ? REQ_M1 : REQ_M0;
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares the single-port on-chip RAM between two Avalon-MM masters:
// same-cycle grant, one-cycle read return, reset_req stalls all traffic.
module onchip_mem_arbiter #(
    parameter int ADDR_W     = onchip_mem_pkg::ADDR_W,
    parameter int DATA_W     = onchip_mem_pkg::DATA_W,
    parameter int BE_W       = onchip_mem_pkg::BE_W,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reset_req,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    import onchip_mem_pkg::*;

    logic       w_block;
    logic [1:0] w_req;
    logic [1:0] w_gnt;
    logic       w_sel1;
    logic       w_rd_acc;
    logic       r_rd_pend;
    req_id_t    r_rd_id;

    // No grants while in reset or while the memory is being protected.
    assign w_block = reset | reset_req;
    assign w_req   = {m1_read | m1_write, m0_read | m0_write} & {2{~w_block}};

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    // Data mux defaults to m0 when nobody is granted.
    assign w_sel1         = w_gnt[1];
    assign ram_address    = w_sel1 ? m1_address    : m0_address;
    assign ram_byteenable = w_sel1 ? m1_byteenable : m0_byteenable;
    assign ram_writedata  = w_sel1 ? m1_writedata  : m0_writedata;
    assign ram_chipselect = |w_gnt;
    assign ram_write      = (w_gnt[0] & m0_write) | (w_gnt[1] & m1_write);
    assign ram_clken      = ~reset_req;

    assign m0_waitrequest = ~w_gnt[0];
    assign m1_waitrequest = ~w_gnt[1];

    // read+write together is a write: no read return for it.
    assign w_rd_acc = (w_gnt[0] & m0_read & ~m0_write) |
                      (w_gnt[1] & m1_read & ~m1_write);

    // Read-return pipeline: one outstanding slot, refilled every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_pend <= 1'b0;
            r_rd_id   <= REQ_M0;
        end else begin
            r_rd_pend <= w_rd_acc;
            if (w_rd_acc)
                r_rd_id <= w_sel1 ? REQ_M1 : REQ_M0;
        end
    end

    // RAM q is routed to both masters; readdatavalid qualifies it.
    // Gating with reset drops a return that lands in a reset cycle.
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;
    assign m0_readdatavalid = r_rd_pend & ~reset & (r_rd_id == REQ_M0);
    assign m1_readdatavalid = r_rd_pend & ~reset & (r_rd_id == REQ_M1);

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Two-requester arbiter that shares the single-port 256K×32 on-chip main memory (18-bit word address, 4 byte lanes, one-cycle read latency, clken/reset_req gating) between two Avalon-MM masters, typically a Nios core data port and a DMA/fingerprint engine. It grants at most one RAM access per cycle with round-robin fairness, returns read data with `readdatavalid`, and stalls all traffic while `reset_req` is asserted. It sits between the system interconnect and the RAM wrapper and is the only driver of the RAM's port.

## Interface
- `ADDR_W`, default 18: word address width.
- `DATA_W`, default 32: data width.
- `BE_W`, default 4: byte-enable width (DATA_W/8).
- `FIXED_PRIO`, default 0: 0 selects round-robin; 1 means requester 0 always wins.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `reset_req`  in  1  memory-protect request; blocks new grants.
- `m0_address` / `m1_address`  in  ADDR_W  word address.
- `m0_byteenable` / `m1_byteenable`  in  BE_W  byte lanes for writes.
- `m0_read` / `m1_read`  in  1  read request.
- `m0_write` / `m1_write`  in  1  write request.
- `m0_writedata` / `m1_writedata`  in  DATA_W  write data.
- `m0_waitrequest` / `m1_waitrequest`  out  1  high = request not accepted this cycle.
- `m0_readdata` / `m1_readdata`  out  DATA_W  read data.
- `m0_readdatavalid` / `m1_readdatavalid`  out  1  readdata valid.
- `ram_address`  out  ADDR_W; `ram_byteenable`  out  BE_W; `ram_writedata`  out  DATA_W.
- `ram_chipselect`  out  1; `ram_write`  out  1; `ram_clken`  out  1.
- `ram_readdata`  in  DATA_W  RAM q, valid the cycle after the address edge.

## Operation
- A requester is pending when `read|write` is high. If both are high, it is treated as a write, and read is ignored with no readdatavalid.
- Arbitration is combinational each cycle over the pending set.
  - FIXED_PRIO=1: m0 wins.
  - FIXED_PRIO=0: the requester not equal to `last_grant` wins when both are pending; a lone pending requester always wins.
- Winner: its `waitrequest`=0 this cycle, and its address/byteenable/writedata/write are muxed to the RAM with `ram_chipselect`=1. The loser holds `waitrequest`=1 and must keep its signals stable.
- `last_grant` updates to the winner on the accepting edge. Its reset value is 1, so m0 wins first.
- Read accepted in cycle t: register `rd_pend`=1 and `rd_id`=winner at the edge. In t+1, `ram_readdata` is routed to `m<rd_id>_readdata` and that requester's `readdatavalid`=1. Back-to-back reads pipeline at one per cycle.
- `m*_readdata` carries `ram_readdata` unconditionally. Masters qualify it only with `readdatavalid`.
- `ram_clken` = ~reset_req.
  - While `reset_req`=1: no grant, both `waitrequest`=1, `ram_chipselect`=0.
  - A read accepted in the cycle before `reset_req` rises still completes: its readdatavalid fires in the first reset_req cycle. The RAM output is held unregistered, so data is valid.
- No grant: `ram_chipselect`=0, `ram_write`=0, and address/data are don't-care (driven from m0).

## Timing
- Acceptance is same-cycle, with a combinational path from request inputs to waitrequest and the ram_* outputs.
- Read latency: exactly 1 cycle from the accept edge to readdatavalid. Write completes at the accept edge.
- Throughput: 1 access/cycle total. Under continuous contention in round-robin, grants alternate m0, m1, m0, …
- During `reset`=1, and at the first edge after:
  - `rd_pend`=0 and `last_grant`=1.
  - Both `waitrequest`=1 and both `readdatavalid`=0.
  - `ram_chipselect`=0, `ram_write`=0, `ram_clken`=1.
- Reset mid-read: the pending readdatavalid is dropped.
- Simultaneous read accept and readdatavalid for the same or the other requester: both are legal in the same cycle.

## Structure
- Shared package `onchip_mem_pkg`: ADDR_W, DATA_W, BE_W constants, and the requester-ID type (1 bit).
- Sub-module `rr_arb2`: 2-bit request in, one-hot grant out, `last_grant` register, FIXED_PRIO parameter.
- Top level: the data mux, the read-return pipeline (`rd_pend`, `rd_id`), and the reset_req gating.

## Test plan
- m0 write 0xDEADBEEF @0x00010 be=4'hF, then m0 read @0x00010 → m0_readdatavalid one cycle after accept with 0xDEADBEEF; m1 sees no valid.
- m0 and m1 both read continuously for 8 cycles → grants alternate m0,m1,…, starting with m0; each gets 4 readdatavalid with correct data.
- m1 byte write be=4'b0100 data 0x00AA0000 over 0x11111111 → readback 0x11AA1111.
- Read accepted, then `reset_req`=1 for 5 cycles with both masters requesting → that read's valid appears, then both waitrequest=1 and ram_chipselect=0 for 5 cycles; traffic resumes on drop.
- FIXED_PRIO=1 with both requesting for 6 cycles → m0 wins all 6, m1 waitrequest stays 1.
- `reset` asserted in the cycle after a read accept → no readdatavalid; after release, the first contended grant goes to m0.
